// File: rtl/xin_input_filter_pkg.sv
// Shared motor-board constants used by the Xin input conditioning stage.
package xin_input_filter_pkg;

  localparam int unsigned CLK_HZ       = 25_000_000;
  localparam int unsigned DB_1MS       = 25000;
  localparam int unsigned XIN_CH       = 8;
  localparam logic [7:0]  XIN_INIT_LVL = 8'h00;

endpackage

// File: rtl/xin_debounce_ch.sv
// Single-channel input conditioner: two-stage synchroniser followed by a
// stable-count debouncer that drives the clean level and a change pulse.
module xin_debounce_ch
  import xin_input_filter_pkg::*;
#(
  parameter int unsigned DB_LIMIT = DB_1MS,
  parameter int unsigned DB_W     = 16,
  parameter logic        INIT_BIT = 1'b0
) (
  input  logic Clk,
  input  logic nRst,
  input  logic xinRaw,
  output logic levelOut,
  output logic edgePls
);

  localparam logic [DB_W-1:0] LIMIT_M1 = DB_W'(DB_LIMIT - 1);

  logic            syncS1;
  logic            syncS2;
  logic [DB_W-1:0] stableCnt;

  // Synchronise the pin, then accept s2 only after it has differed from the
  // current level for DB_LIMIT consecutive cycles; any agreement restarts.
  always_ff @(posedge Clk) begin
    if (!nRst) begin
      syncS1    <= INIT_BIT;
      syncS2    <= INIT_BIT;
      levelOut  <= INIT_BIT;
      stableCnt <= '0;
      edgePls   <= 1'b0;
    end else begin
      syncS1  <= xinRaw;
      syncS2  <= syncS1;
      edgePls <= 1'b0;
      if (syncS2 == levelOut) begin
        stableCnt <= '0;
      end else if (stableCnt == LIMIT_M1) begin
        levelOut  <= syncS2;
        stableCnt <= '0;
        edgePls   <= 1'b1;
      end else begin
        stableCnt <= stableCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/xin_input_filter.sv
// Eight-channel Xin conditioning stage: per-channel debounce, sticky
// rise/fall event flags with MCU clear strobes, and a masked interrupt request.
module xin_input_filter
  import xin_input_filter_pkg::*;
#(
  parameter int unsigned      CH       = XIN_CH,
  parameter int unsigned      DB_LIMIT = DB_1MS,
  parameter int unsigned      DB_W     = 16,
  parameter logic [CH-1:0]    INIT_LVL = CH'(XIN_INIT_LVL)
) (
  input  logic          Clk,
  input  logic          nRst,
  input  logic [CH-1:0] Xin,
  input  logic [CH-1:0] ClrRise,
  input  logic [CH-1:0] ClrFall,
  input  logic [CH-1:0] IrqEn,
  output logic [CH-1:0] Xout,
  output logic [CH-1:0] RiseFlag,
  output logic [CH-1:0] FallFlag,
  output logic [CH-1:0] EdgePls,
  output logic          IrqReq
);

  logic [CH-1:0] riseSet;
  logic [CH-1:0] fallSet;

  for (genvar i = 0; i < CH; i++) begin : gChan
    xin_debounce_ch #(
      .DB_LIMIT (DB_LIMIT),
      .DB_W     (DB_W),
      .INIT_BIT (INIT_LVL[i])
    ) uDebounce (
      .Clk      (Clk),
      .nRst     (nRst),
      .xinRaw   (Xin[i]),
      .levelOut (Xout[i]),
      .edgePls  (EdgePls[i])
    );
  end

  // A change pulse qualified by the new level tells us which edge occurred.
  always_comb begin
    riseSet = EdgePls & Xout;
    fallSet = EdgePls & ~Xout;
  end

  // Sticky flags where a same-cycle set beats the clear, plus the masked
  // interrupt request registered from the current flag state.
  always_ff @(posedge Clk) begin
    if (!nRst) begin
      RiseFlag <= '0;
      FallFlag <= '0;
      IrqReq   <= 1'b0;
    end else begin
      RiseFlag <= (RiseFlag & ~ClrRise) | riseSet;
      FallFlag <= (FallFlag & ~ClrFall) | fallSet;
      IrqReq   <= |((RiseFlag | FallFlag) & IrqEn);
    end
  end

endmodule

// File: tb/tb_xin_input_filter.sv
// Directed bench for xin_input_filter with DB_LIMIT=4 (accept latency 6 edges).
module tb_xin_input_filter;

  logic       Clk = 1'b0;
  logic       nRst;
  logic [7:0] Xin;
  logic [7:0] ClrRise;
  logic [7:0] ClrFall;
  logic [7:0] IrqEn;
  logic [7:0] Xout;
  logic [7:0] RiseFlag;
  logic [7:0] FallFlag;
  logic [7:0] EdgePls;
  logic       IrqReq;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] edgeSeen;

  xin_input_filter #(
    .CH       (8),
    .DB_LIMIT (4),
    .DB_W     (16),
    .INIT_LVL (8'h00)
  ) dut (
    .Clk      (Clk),
    .nRst     (nRst),
    .Xin      (Xin),
    .ClrRise  (ClrRise),
    .ClrFall  (ClrFall),
    .IrqEn    (IrqEn),
    .Xout     (Xout),
    .RiseFlag (RiseFlag),
    .FallFlag (FallFlag),
    .EdgePls  (EdgePls),
    .IrqReq   (IrqReq)
  );

  // 25 MHz-style free-running clock
  always #5 Clk = ~Clk;

  // Advance to just after the next rising edge; inputs and checks happen here.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 'h%0h expected 'h%0h", tag, observed, expected);
    end
  endtask

  initial begin
    nRst = 1'b0; Xin = 8'hFF; ClrRise = 8'h00; ClrFall = 8'h00; IrqEn = 8'h00;

    // Reset with all pins high, then release.
    applyStimulus(3);
    checkOutput("rst_xout", Xout, 8'h00);
    checkOutput("rst_rise", RiseFlag, 8'h00);
    checkOutput("rst_fall", FallFlag, 8'h00);
    checkOutput("rst_edge", EdgePls, 8'h00);
    checkOutput("rst_irq", IrqReq, 1'b0);
    nRst = 1'b1;
    applyStimulus(5);
    checkOutput("steady_pre", Xout, 8'h00);
    applyStimulus(1);
    checkOutput("steady_xout", Xout, 8'hFF);
    checkOutput("steady_edge", EdgePls, 8'hFF);
    checkOutput("steady_rise_early", RiseFlag, 8'h00);
    applyStimulus(1);
    checkOutput("steady_rise", RiseFlag, 8'hFF);
    checkOutput("steady_fall", FallFlag, 8'h00);
    checkOutput("steady_edge_end", EdgePls, 8'h00);
    ClrRise = 8'hFF;
    applyStimulus(1);
    ClrRise = 8'h00;
    checkOutput("clr_all_rise", RiseFlag, 8'h00);

    // Return all channels low and clear the fall flags.
    Xin = 8'h00;
    applyStimulus(6);
    checkOutput("all_low", Xout, 8'h00);
    applyStimulus(1);
    checkOutput("all_fall", FallFlag, 8'hFF);
    ClrFall = 8'hFF;
    applyStimulus(1);
    ClrFall = 8'h00;
    checkOutput("clr_all_fall", FallFlag, 8'h00);

    // Three-cycle glitch on channel 2 must never be accepted.
    edgeSeen = 8'h00;
    Xin = 8'h04;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1);
      edgeSeen |= EdgePls;
    end
    Xin = 8'h00;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1);
      edgeSeen |= EdgePls;
    end
    checkOutput("glitch_xout", Xout, 8'h00);
    checkOutput("glitch_edge", edgeSeen, 8'h00);
    checkOutput("glitch_rise", RiseFlag, 8'h00);

    // Channel 5 accepted high, held, then accepted low.
    Xin = 8'h20;
    applyStimulus(5);
    checkOutput("ch5_rise_pre", Xout, 8'h00);
    applyStimulus(1);
    checkOutput("ch5_rise_xout", Xout, 8'h20);
    checkOutput("ch5_rise_edge", EdgePls, 8'h20);
    applyStimulus(1);
    checkOutput("ch5_riseflag", RiseFlag, 8'h20);
    applyStimulus(3);
    Xin = 8'h00;
    applyStimulus(5);
    checkOutput("ch5_fall_pre", Xout, 8'h20);
    applyStimulus(1);
    checkOutput("ch5_fall_xout", Xout, 8'h00);
    checkOutput("ch5_fall_edge", EdgePls, 8'h20);
    applyStimulus(1);
    checkOutput("ch5_fallflag", FallFlag, 8'h20);
    checkOutput("ch5_riseflag_kept", RiseFlag, 8'h20);
    ClrRise = 8'h20; ClrFall = 8'h20;
    applyStimulus(1);
    ClrRise = 8'h00; ClrFall = 8'h00;
    checkOutput("ch5_clr_rise", RiseFlag, 8'h00);
    checkOutput("ch5_clr_fall", FallFlag, 8'h00);

    // Clear strobe coincident with the set condition on channel 0: set wins.
    Xin = 8'h01;
    applyStimulus(6);
    checkOutput("coll_edge", EdgePls, 8'h01);
    ClrRise = 8'h01;
    applyStimulus(1);
    ClrRise = 8'h00;
    checkOutput("coll_set_wins", RiseFlag, 8'h01);
    ClrRise = 8'h01;
    applyStimulus(1);
    ClrRise = 8'h00;
    checkOutput("coll_clear", RiseFlag, 8'h00);

    // Interrupt masking with an event on channel 3 only.
    IrqEn = 8'h01;
    Xin = 8'h09;
    applyStimulus(7);
    checkOutput("irq_flag3", RiseFlag, 8'h08);
    applyStimulus(2);
    checkOutput("irq_masked", IrqReq, 1'b0);
    IrqEn = 8'h08;
    applyStimulus(1);
    checkOutput("irq_enabled", IrqReq, 1'b1);
    ClrRise = 8'h08;
    applyStimulus(1);
    ClrRise = 8'h00;
    checkOutput("irq_clr_plus1", IrqReq, 1'b1);
    applyStimulus(1);
    checkOutput("irq_clr_plus2", IrqReq, 1'b0);

    // Reset in the middle of a channel 7 debounce count.
    IrqEn = 8'h00;
    Xin = 8'h89;
    applyStimulus(3);
    nRst = 1'b0;
    applyStimulus(1);
    nRst = 1'b1;
    checkOutput("midrst_xout", Xout, 8'h00);
    checkOutput("midrst_edge", EdgePls, 8'h00);
    applyStimulus(5);
    checkOutput("midrst_pre", Xout, 8'h00);
    applyStimulus(1);
    checkOutput("midrst_xout_rise", Xout, 8'h89);
    applyStimulus(1);
    checkOutput("midrst_rise", RiseFlag, 8'h89);
    checkOutput("midrst_fall", FallFlag, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
